// File: rtl/rx_cap_pkg.sv
// Shared types and helpers for the rx capture burst writer.
// FSM states, counter width and a saturating increment.
package rx_cap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    BURST,
    FLUSH
  } state_t;

  localparam int CNT_W = 16;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rx_cap_fifo.sv
// Show-ahead synchronous FIFO with fill count.
// Push and pop in the same cycle are legal even when full.
module rx_cap_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty   = (fill == '0);
  assign full    = (fill == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rp];

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

  // Pointers and fill count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp   <= '0;
      rp   <= '0;
      fill <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

endmodule

// File: rtl/rx_capture_burst_writer.sv
// Sample stream to Avalon-MM ring buffer burst writer.
// Define RX_CAP_DROP_EN to drop beats on overflow instead of stalling.
module rx_capture_burst_writer
  import rx_cap_pkg::*;
#(
  parameter int SAMPLE_W   = 16,
  parameter int CHANNELS   = 2,
  parameter int ADDR_W     = 32,
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 32,
  localparam int DATA_W    = SAMPLE_W * CHANNELS,
  localparam int BC_W      = $clog2(BURST_LEN) + 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_words,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic [BC_W-1:0]   avm_burstcount,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [CNT_W-1:0]  wrap_count,
  output logic              overflow,
  output logic [CNT_W-1:0]  drop_count
);

  localparam int FW  = $clog2(FIFO_DEPTH) + 1;
  localparam int BSH = $clog2(DATA_W / 8);

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] words_q;
  logic              enabled;
  logic              stop_pend;
  logic [BC_W-1:0]   beats_left;
  logic [FW-1:0]     fill;
  logic              full;
  logic [DATA_W-1:0] head;
  logic              push;
  logic              beat_ok;

  assign beat_ok       = avm_write & ~avm_waitrequest;
  assign busy          = (state != IDLE);
  assign avm_writedata = avm_write ? head : '0;

`ifdef RX_CAP_DROP_EN
  logic drop;

  assign in_ready = enabled;
  assign push     = in_valid & enabled & ~full;
  assign drop     = in_valid & enabled & full;

  // Sticky overflow flag and saturating drop counter
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (state == IDLE && start) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      drop_count <= sat_inc(drop_count);
    end
  end
`else
  assign in_ready   = enabled & ~full;
  assign push       = in_valid & in_ready;
  assign overflow   = 1'b0;
  assign drop_count = '0;
`endif

  rx_cap_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .push  (push),
    .wdata (in_data),
    .pop   (beat_ok),
    .rdata (head),
    .fill  (fill),
    .full  (full)
  );

  // Capture control FSM with registered Avalon request outputs
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state          <= IDLE;
      base_q         <= '0;
      words_q        <= '0;
      enabled        <= 1'b0;
      stop_pend      <= 1'b0;
      beats_left     <= '0;
      avm_address    <= '0;
      avm_write      <= 1'b0;
      avm_burstcount <= '0;
      wr_ptr         <= '0;
      wrap_count     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= ARM;
            base_q     <= cfg_base;
            words_q    <= cfg_words;
            enabled    <= 1'b1;
            stop_pend  <= 1'b0;
            wr_ptr     <= '0;
            wrap_count <= '0;
          end
        end
        ARM: begin
          if (fill >= FW'(BURST_LEN)) begin
            state          <= BURST;
            avm_address    <= base_q + (wr_ptr << BSH);
            avm_burstcount <= BC_W'(BURST_LEN);
            beats_left     <= BC_W'(BURST_LEN);
            avm_write      <= 1'b1;
          end else if (stop_pend && fill != '0) begin
            state          <= FLUSH;
            avm_address    <= base_q + (wr_ptr << BSH);
            avm_burstcount <= BC_W'(fill);
            beats_left     <= BC_W'(fill);
            avm_write      <= 1'b1;
          end else if (stop_pend) begin
            state     <= IDLE;
            stop_pend <= 1'b0;
          end
        end
        BURST, FLUSH: begin
          if (beat_ok) begin
            beats_left <= beats_left - 1'b1;
            if (wr_ptr + 1'b1 == words_q) begin
              wr_ptr     <= '0;
              wrap_count <= sat_inc(wrap_count);
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
            if (beats_left == BC_W'(1)) begin
              avm_write <= 1'b0;
              if (state == FLUSH) begin
                state     <= IDLE;
                stop_pend <= 1'b0;
              end else begin
                state <= ARM;
              end
            end
          end
        end
      endcase
      if (stop && state != IDLE) begin
        enabled   <= 1'b0;
        stop_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rx_capture_burst_writer.sv
// Directed bench for rx_capture_burst_writer.
// Expected Avalon beats are queued by stimulus and popped by a monitor.
module tb_rx_capture_burst_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop;
  logic [31:0] cfg_base, cfg_words;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_burstcount;
  logic        avm_waitrequest;
  logic        busy;
  logic [31:0] wr_ptr;
  logic [15:0] wrap_count;
  logic        overflow;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  rx_capture_burst_writer dut (
    .clk_clk         (clk),
    .reset_reset_n   (rst_n),
    .start           (start),
    .stop            (stop),
    .cfg_base        (cfg_base),
    .cfg_words       (cfg_words),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .avm_address     (avm_address),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_burstcount  (avm_burstcount),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .wr_ptr          (wr_ptr),
    .wrap_count      (wrap_count),
    .overflow        (overflow),
    .drop_count      (drop_count)
  );

  typedef struct {
    logic [31:0] a;
    logic [3:0]  bc;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks    = 0;
  int   failures  = 0;
  int   mon_count = 0;

  function automatic logic [31:0] pat(input int t, input int i);
    return {16'(16'hA000 + t * 256 + i), 16'(16'h5000 + t * 256 + i)};
  endfunction

  task automatic chk(input string nm, input logic [95:0] act,
                     input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [3:0] bc,
                          input logic [31:0] d);
    exp_t e;
    e.a = a; e.bc = bc; e.d = d;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: a beat is accepted on the coming edge
  always @(negedge clk) begin
    if (rst_n && avm_write && !avm_waitrequest) begin
      mon_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL beat_unexpected: got addr %0h data %0h expected none",
                 avm_address, avm_writedata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("beat_addr", 96'(avm_address), 96'(mon_e.a));
        chk("beat_bc", 96'(avm_burstcount), 96'(mon_e.bc));
        chk("beat_data", 96'(avm_writedata), 96'(mon_e.d));
      end
    end
  end

  task automatic do_start(input logic [31:0] b, input logic [31:0] w);
    cfg_base = b; cfg_words = w; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
  endtask

  task automatic send(input logic [31:0] d);
    int   n;
    logic ok;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 500);
    chk(nm, 96'(busy), 96'(0));
    @(posedge clk); #1;
  endtask

  task automatic wait_mon(input int tgt);
    int n;
    n = 0;
    while (mon_count < tgt && n < 500) begin
      @(posedge clk); #2;
      n++;
    end
    chk("wait_mon", 96'(mon_count >= tgt), 96'(1));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_in_ready"}, 96'(in_ready), 96'(0));
    chk({nm, "_write"}, 96'(avm_write), 96'(0));
    chk({nm, "_addr"}, 96'(avm_address), 96'(0));
    chk({nm, "_bc"}, 96'(avm_burstcount), 96'(0));
    chk({nm, "_wdata"}, 96'(avm_writedata), 96'(0));
    chk({nm, "_busy"}, 96'(busy), 96'(0));
    chk({nm, "_wr_ptr"}, 96'(wr_ptr), 96'(0));
    chk({nm, "_wraps"}, 96'(wrap_count), 96'(0));
    chk({nm, "_ovf"}, 96'(overflow), 96'(0));
    chk({nm, "_drops"}, 96'(drop_count), 96'(0));
  endtask

  task automatic stall_proc(input int tgt);
    wait_mon(tgt);
    avm_waitrequest = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_addr", 96'(avm_address), 96'h1000);
      chk("stall_bc", 96'(avm_burstcount), 96'(8));
      chk("stall_data", 96'(avm_writedata), 96'(pat(4, 3)));
      chk("stall_write", 96'(avm_write), 96'(1));
    end
    @(posedge clk); #2;
    avm_waitrequest = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int   idx;
    int   m0;
    logic ok;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_base = '0; cfg_words = '0;
    in_valid = 1'b0; in_data = '0; avm_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back streaming
    for (int i = 0; i < 24; i++)
      push_exp(32'h1000 + 32'((i / 8) * 32), 4'd8, pat(1, i));
    do_start(32'h1000, 32'd64);
    for (int i = 0; i < 24; i++) send(pat(1, i));
    do_stop();
    wait_idle("t1_idle");
    chk("t1_wr_ptr", 96'(wr_ptr), 96'(24));
    chk("t1_wraps", 96'(wrap_count), 96'(0));
    chk("t1_drain", 96'(exp_q.size()), 96'(0));

    // Ring wrap
    for (int i = 0; i < 40; i++)
      push_exp(32'h1000 + 32'(((i / 8) % 2) * 32), 4'd8, pat(2, i));
    do_start(32'h1000, 32'd16);
    for (int i = 0; i < 40; i++) send(pat(2, i));
    do_stop();
    wait_idle("t2_idle");
    chk("t2_wr_ptr", 96'(wr_ptr), 96'(8));
    chk("t2_wraps", 96'(wrap_count), 96'(2));
    chk("t2_drain", 96'(exp_q.size()), 96'(0));

    // Partial flush
    for (int i = 0; i < 8; i++) push_exp(32'h1000, 4'd8, pat(3, i));
    for (int i = 8; i < 11; i++) push_exp(32'h1020, 4'd3, pat(3, i));
    do_start(32'h1000, 32'd64);
    for (int i = 0; i < 11; i++) send(pat(3, i));
    do_stop();
    wait_idle("t3_idle");
    chk("t3_wr_ptr", 96'(wr_ptr), 96'(11));
    chk("t3_drain", 96'(exp_q.size()), 96'(0));

    // Slave stall on beat 3
    for (int i = 0; i < 8; i++) push_exp(32'h1000, 4'd8, pat(4, i));
    do_start(32'h1000, 32'd64);
    m0 = mon_count;
    fork
      begin
        for (int i = 0; i < 8; i++) send(pat(4, i));
      end
      stall_proc(m0 + 3);
    join
    do_stop();
    wait_idle("t4_idle");
    chk("t4_beats", 96'(mon_count - m0), 96'(8));
    chk("t4_wr_ptr", 96'(wr_ptr), 96'(8));
    chk("t4_drain", 96'(exp_q.size()), 96'(0));

    // Overflow with the slave stalled
    for (int i = 0; i < 32; i++)
      push_exp(32'h1000 + 32'((i / 8) * 32), 4'd8, pat(5, i));
    avm_waitrequest = 1'b1;
    do_start(32'h1000, 32'd64);
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      in_valid = 1'b1;
      in_data  = pat(5, idx);
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      if (ok) idx++;
    end
    in_valid = 1'b0;
    @(negedge clk);
`ifdef RX_CAP_DROP_EN
    chk("t5_accepted", 96'(idx), 96'(40));
    chk("t5_in_ready", 96'(in_ready), 96'(1));
    chk("t5_drops", 96'(drop_count), 96'(8));
    chk("t5_ovf", 96'(overflow), 96'(1));
`else
    chk("t5_accepted", 96'(idx), 96'(32));
    chk("t5_in_ready", 96'(in_ready), 96'(0));
    chk("t5_drops", 96'(drop_count), 96'(0));
    chk("t5_ovf", 96'(overflow), 96'(0));
`endif
    @(posedge clk); #1;
    avm_waitrequest = 1'b0;
    do_stop();
    wait_idle("t5_idle");
    chk("t5_wr_ptr", 96'(wr_ptr), 96'(32));
    chk("t5_drain", 96'(exp_q.size()), 96'(0));

    // Reset mid-burst at beat 4, then restart
    for (int i = 0; i < 4; i++) push_exp(32'h1000, 4'd8, pat(6, i));
    do_start(32'h1000, 32'd64);
    m0 = mon_count;
    for (int i = 0; i < 8; i++) send(pat(6, i));
    wait_mon(m0 + 4);
    rst_n = 1'b0;
    #1;
    chk_zero("t6_rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("t6_drain_rst", 96'(exp_q.size()), 96'(0));
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) push_exp(32'h2000, 4'd8, pat(7, i));
    do_start(32'h2000, 32'd64);
    for (int i = 0; i < 8; i++) send(pat(7, i));
    do_stop();
    wait_idle("t6_idle");
    chk("t6_wr_ptr", 96'(wr_ptr), 96'(8));
    chk("t6_drain", 96'(exp_q.size()), 96'(0));

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
